// File: rtl/shift_65b_rx_if.sv
// Serial link bundle between the load-and-shift transmitter side and the receiver.
// Carries the shared load strobe, the serial line and the received word/status.
// master = link driver / consumer of results, slave = the receiver block.
interface shift_65b_rx_if #(
    parameter int DATA_W = 64
);
    logic              start;
    logic              ser_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              frame_err;
    logic              busy;

    modport master (
        output start,
        output ser_in,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  start,
        input  ser_in,
        output data_out,
        output data_valid,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/shift_65b_rx.sv
// Serial-to-parallel receiver: rebuilds a DATA_W-bit LSB-first frame and checks its 0 marker bit.
// Latency: data_valid/frame_err high in the cycle after edge k+DATA_W+2 (k = last start edge).
// No backpressure: the link is free-running; start always wins and aborts any frame in flight.
module shift_65b_rx #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_65b_rx_if.slave     bus
);
    localparam int CW = $clog2(DATA_W + 1);
    // Counter value on the edge that captures the final data bit.
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        CHECK = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              vld_q, vld_d;
    logic              err_q, err_d;

    // State, counter, shift register and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; start overrides everything, including the marker decision.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        if (bus.start) begin
            state_d = LOAD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Idle-high fill on the line is deliberately ignored.
                    state_d = IDLE;
                end
                LOAD: begin
                    // Line still carries stale data on this edge: no sample.
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
                SHIFT: begin
                    shreg_d = {bus.ser_in, shreg_q[DATA_W-1:1]};
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (!bus.ser_in) begin
                        data_d = shreg_q;
                        vld_d  = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = vld_q;
    assign bus.frame_err  = err_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_shift_65b_rx.sv
module tb_shift_65b_rx;
    localparam int W = 64;

    logic clk;
    logic rst_n;

    shift_65b_rx_if #(.DATA_W(W)) bus ();

    shift_65b_rx #(.DATA_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (edge-time %0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: classify every edge by its distance from the last
    // start edge. Distance 2..W+1 samples data bit d-2, W+2 samples marker.
    // ------------------------------------------------------------------
    int          n = 0;
    bit          m_active = 1'b0;
    int          m_k = 0;
    logic [W-1:0] m_bits = '0;
    logic        exp_vld = 1'b0;
    logic        exp_err = 1'b0;
    logic        exp_busy = 1'b0;
    logic [W-1:0] exp_data = '0;

    always @(posedge clk) begin
        int d;
        n++;
        exp_vld = 1'b0;
        exp_err = 1'b0;
        if (!rst_n) begin
            m_active = 1'b0;
            exp_data = '0;
        end else if (bus.start) begin
            m_active = 1'b1;
            m_k      = n;
        end else if (m_active) begin
            d = n - m_k;
            if (d >= 2 && d <= W + 1) begin
                m_bits[d-2] = bus.ser_in;
            end else if (d == W + 2) begin
                if (bus.ser_in == 1'b0) begin
                    exp_vld  = 1'b1;
                    exp_data = m_bits;
                end else begin
                    exp_err = 1'b1;
                end
                m_active = 1'b0;
            end
        end
        exp_busy = m_active;
    end

    always @(negedge rst_n) begin
        m_active = 1'b0;
        exp_vld  = 1'b0;
        exp_err  = 1'b0;
        exp_busy = 1'b0;
        exp_data = '0;
    end

    // Monitor: compare every cycle, away from the active edge.
    int vld_cnt = 0;
    int err_cnt = 0;
    int vld_edges[$];

    always @(negedge clk) begin
        chk("data_valid", 64'(bus.data_valid), 64'(exp_vld));
        chk("frame_err",  64'(bus.frame_err),  64'(exp_err));
        chk("busy",       64'(bus.busy),       64'(exp_busy));
        chk("data_out",   bus.data_out,        exp_data);
        if (bus.data_valid === 1'b1) begin
            vld_cnt++;
            vld_edges.push_back(n);
        end
        if (bus.frame_err === 1'b1) begin
            err_cnt++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: transmitter behaviour driven from the bench.
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // hold: start cycles; bad: marker forced to 1; abort_at: bit index
    // (0..W, W = marker) at which the frame is abandoned, -1 for none.
    // Returns just after edge k+W+2 (or at the abort point) with k = last start edge.
    task automatic tx_frame(input logic [W-1:0] w, input int hold, input bit bad,
                            input int abort_at, output int k);
        logic b;
        bus.start = 1'b1;
        for (int i = 0; i < hold; i++) begin
            bus.ser_in = 1'($urandom_range(1, 0));
            step();
        end
        k = n;
        bus.start  = 1'b0;
        bus.ser_in = 1'($urandom_range(1, 0));
        step();
        for (int i = 0; i <= W; i++) begin
            b = (i < W) ? w[i] : bad;
            if (abort_at == i) begin
                return;
            end
            bus.ser_in = b;
            step();
        end
        bus.ser_in = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, n_cmp=%0d expected completion", n_cmp);
        $fatal(1);
    end

    initial begin
        int k, k1, k2, c0, e0;
        logic [W-1:0] w, w2;
        logic [W-1:0] ones;
        ones = '1;

        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.ser_in = 1'b1;
        step();
        chk("rst_busy",  64'(bus.busy), 64'd0);
        chk("rst_vld",   64'(bus.data_valid), 64'd0);
        chk("rst_data",  bus.data_out, 64'd0);
        step();
        rst_n = 1'b1;
        repeat (3) step();

        // Nominal frame.
        vld_edges.delete();
        c0 = vld_cnt;
        tx_frame(64'hDEAD_BEEF_0123_4567, 1, 1'b0, -1, k);
        step();
        chk("nom_data",    bus.data_out, 64'hDEAD_BEEF_0123_4567);
        chk("nom_vld_cnt", 64'(vld_cnt - c0), 64'd1);
        if (vld_edges.size() == 1) chk("nom_latency", 64'(vld_edges[0] - k), 64'd66);
        else chk("nom_vld_edges", 64'(vld_edges.size()), 64'd1);

        // Bad marker.
        c0 = vld_cnt; e0 = err_cnt;
        tx_frame(64'hDEAD_BEEF_0123_4567, 1, 1'b1, -1, k);
        step();
        chk("bad_err_cnt", 64'(err_cnt - e0), 64'd1);
        chk("bad_vld_cnt", 64'(vld_cnt - c0), 64'd0);
        chk("bad_hold",    bus.data_out, 64'hDEAD_BEEF_0123_4567);

        // Abort 20 cycles into a frame.
        c0 = vld_cnt; e0 = err_cnt;
        tx_frame(64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0, 20, k);
        tx_frame(64'h0000_0000_0000_0001, 1, 1'b0, -1, k);
        step();
        chk("abort_vld_cnt", 64'(vld_cnt - c0), 64'd1);
        chk("abort_err_cnt", 64'(err_cnt - e0), 64'd0);
        chk("abort_data",    bus.data_out, 64'h0000_0000_0000_0001);

        // Long start, then back-to-back frame.
        vld_edges.delete();
        tx_frame(64'h8000_0000_0000_0000, 3, 1'b0, -1, k1);
        tx_frame(64'h5555_AAAA_5555_AAAA, 1, 1'b0, -1, k2);
        step();
        chk("b2b_count", 64'(vld_edges.size()), 64'd2);
        if (vld_edges.size() == 2) begin
            chk("long_latency", 64'(vld_edges[0] - k1), 64'd66);
            chk("b2b_latency",  64'(vld_edges[1] - k2), 64'd66);
        end
        chk("b2b_data", bus.data_out, 64'h5555_AAAA_5555_AAAA);

        // All ones, then all zeros with missing marker.
        tx_frame(ones, 1, 1'b0, -1, k);
        step();
        chk("ones_data", bus.data_out, ones);
        e0 = err_cnt;
        tx_frame(64'd0, 1, 1'b1, -1, k);
        step();
        chk("zeros_err", 64'(err_cnt - e0), 64'd1);
        chk("zeros_hold", bus.data_out, ones);

        // start on the CHECK edge aborts that frame.
        c0 = vld_cnt; e0 = err_cnt;
        w  = {$urandom, $urandom};
        w2 = {$urandom, $urandom};
        tx_frame(w, 1, 1'b0, W, k);
        tx_frame(w2, 1, 1'b0, -1, k);
        step();
        chk("chk_abort_vld", 64'(vld_cnt - c0), 64'd1);
        chk("chk_abort_err", 64'(err_cnt - e0), 64'd0);
        chk("chk_abort_data", bus.data_out, w2);

        // Reset mid-SHIFT.
        tx_frame({$urandom, $urandom}, 1, 1'b0, 30, k);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_vld",  64'(bus.data_valid), 64'd0);
        chk("mid_rst_err",  64'(bus.frame_err), 64'd0);
        chk("mid_rst_data", bus.data_out, 64'd0);
        step();
        step();
        rst_n = 1'b1;
        c0 = vld_cnt;
        for (int i = 0; i < 80; i++) begin
            bus.ser_in = 1'($urandom_range(1, 0));
            step();
        end
        chk("post_rst_no_vld", 64'(vld_cnt - c0), 64'd0);
        w = {$urandom, $urandom};
        tx_frame(w, 1, 1'b0, -1, k);
        step();
        chk("post_rst_data", bus.data_out, w);

        // Randomized frames: width of start, marker faults, aborts, gaps.
        for (int f = 0; f < 16; f++) begin
            int hold, ab, gap;
            bit bad;
            w    = {$urandom, $urandom};
            hold = $urandom_range(3, 1);
            bad  = ($urandom_range(3, 0) == 0);
            ab   = ($urandom_range(3, 0) == 0) ? int'($urandom_range(W, 0)) : -1;
            tx_frame(w, hold, bad, ab, k);
            gap = $urandom_range(3, 0);
            for (int g = 0; g < gap; g++) begin
                bus.ser_in = 1'($urandom_range(1, 0));
                step();
            end
        end
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
